// File: rtl/frame_seq_pkg.sv
// Shared types for the frame sequencer: state encoding,
// watchdog width and the default wait-state timeout.
package frame_seq_pkg;

  localparam int WD_W = 24;
  localparam logic [WD_W-1:0] TIMEOUT_DEFAULT = 24'd10000000;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ERASE_START,
    S_ERASE_WAIT,
    S_UPDATE,
    S_CHECK,
    S_DRAW_START,
    S_DRAW_WAIT,
    S_DELAY,
    S_DELAY_CLR,
    S_OVER,
    S_FAULT
  } state_t;

  function automatic logic is_wait(state_t s);
    return (s == S_ERASE_WAIT) ||
           (s == S_DRAW_WAIT)  ||
           (s == S_DELAY);
  endfunction

endpackage

// File: rtl/wait_watchdog.sv
// Timeout counter for the sequencer wait states.
// Ports: clk, resetn, clear, count_en, limit -> expired.
module wait_watchdog
  import frame_seq_pkg::*;
(
  input  logic            clk,
  input  logic            resetn,
  input  logic            clear,
  input  logic            count_en,
  input  logic [WD_W-1:0] limit,
  output logic            expired
);

  logic [WD_W-1:0] count;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      count <= '0;
    else if (clear)
      count <= '0;
    else if (count_en)
      count <= count + 1'b1;
  end

  // Count is zero in the first wait cycle, so the limit-th
  // cycle spent waiting is the one that sees count == limit-1.
  assign expired = count_en && (count >= limit - 1'b1);

endmodule

// File: rtl/frame_sequencer.sv
// Per-frame control: erase, update, collision check, draw, delay.
// Ports: clk, resetn, go, plot_done, collision, delay_done in;
//   plot_start, erase, update_pos, delay_en, delay_clr_n,
//   game_over, fault, frame_count out (all registered).
module frame_sequencer
  import frame_seq_pkg::*;
#(
  parameter logic [WD_W-1:0] TIMEOUT_CYCLES = TIMEOUT_DEFAULT,
  parameter int              FRAME_W        = 16
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               go,
  input  logic               plot_done,
  input  logic               collision,
  input  logic               delay_done,
  output logic               plot_start,
  output logic               erase,
  output logic               update_pos,
  output logic               delay_en,
  output logic               delay_clr_n,
  output logic               game_over,
  output logic               fault,
  output logic [FRAME_W-1:0] frame_count
);

  state_t state;
  state_t state_nx;
  logic   wd_clear;
  logic   wd_en;
  logic   wd_exp;
  logic   frame_inc;

  assign wd_en    = is_wait(state);
  assign wd_clear = is_wait(state_nx) && (state_nx != state);

  wait_watchdog u_wd (
    .clk      (clk),
    .resetn   (resetn),
    .clear    (wd_clear),
    .count_en (wd_en),
    .limit    (TIMEOUT_CYCLES),
    .expired  (wd_exp)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      state <= S_IDLE;
    else
      state <= state_nx;
  end

  // Done is tested before the watchdog so a same-cycle done wins.
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:
        if (go) state_nx = S_ERASE_START;
      S_ERASE_START:
        state_nx = S_ERASE_WAIT;
      S_ERASE_WAIT:
        if (plot_done)   state_nx = S_UPDATE;
        else if (wd_exp) state_nx = S_FAULT;
      S_UPDATE:
        state_nx = S_CHECK;
      S_CHECK:
        state_nx = collision ? S_OVER : S_DRAW_START;
      S_DRAW_START:
        state_nx = S_DRAW_WAIT;
      S_DRAW_WAIT:
        if (plot_done)   state_nx = S_DELAY;
        else if (wd_exp) state_nx = S_FAULT;
      S_DELAY:
        if (delay_done)  state_nx = S_DELAY_CLR;
        else if (wd_exp) state_nx = S_FAULT;
      S_DELAY_CLR:
        state_nx = go ? S_ERASE_START : S_IDLE;
      S_OVER:
        if (!go) state_nx = S_IDLE;
      S_FAULT:
        state_nx = S_FAULT;
      default:
        state_nx = S_IDLE;
    endcase
  end

  assign frame_inc = (state == S_DELAY) &&
                     (state_nx == S_DELAY_CLR);

  // Outputs are decoded from the next state and registered so
  // they line up with the state they belong to.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      plot_start  <= 1'b0;
      erase       <= 1'b0;
      update_pos  <= 1'b0;
      delay_en    <= 1'b0;
      delay_clr_n <= 1'b1;
      game_over   <= 1'b0;
      fault       <= 1'b0;
    end else begin
      plot_start  <= (state_nx == S_ERASE_START) ||
                     (state_nx == S_DRAW_START);
      erase       <= (state_nx == S_ERASE_START) ||
                     (state_nx == S_ERASE_WAIT);
      update_pos  <= (state_nx == S_UPDATE);
      delay_en    <= (state_nx == S_DELAY);
      delay_clr_n <= (state_nx != S_DELAY_CLR);
      game_over   <= (state_nx == S_OVER);
      fault       <= (state_nx == S_FAULT);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      frame_count <= '0;
    else if (frame_inc)
      frame_count <= frame_count + 1'b1;
  end

endmodule

// File: doc/frame_sequencer.md
FRAME_SEQUENCER -- requirements
Module: frame_sequencer

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 24'd10000000, SHALL set the watchdog limit in clk cycles for any wait state.
REQ-002 Parameter FRAME_W, default 16, SHALL set the width of frame_count.
REQ-003 clk  input  1  system clock, all state changes on posedge.
REQ-004 resetn  input  1  reset, asynchronous, active-low.
REQ-005 go  input  1  run request; level, 1 = play, 0 = pause after the current frame.
REQ-006 plot_done  input  1  drawing engine finished the requested plot.
REQ-007 collision  input  1  helicopter overlaps an obstacle; sampled only in CHECK.
REQ-008 delay_done  input  1  frame delay timer expired.
REQ-009 plot_start  output  1  one-cycle request to the drawing engine.
REQ-010 erase  output  1  level; 1 = plot in background colour, 0 = plot sprite colour.
REQ-011 update_pos  output  1  one-cycle pulse commanding position/obstacle update.
REQ-012 delay_en  output  1  enable to the frame delay timer.
REQ-013 delay_clr_n  output  1  active-low one-cycle clear to the frame delay timer.
REQ-014 game_over  output  1  level, collision detected.
REQ-015 fault  output  1  sticky watchdog timeout flag.
REQ-016 frame_count  output  FRAME_W  completed frames since reset.

Function
REQ-017 All outputs SHALL be registered; the block SHALL be the initiator of the enable/done handshake toward the frame delay timer and the start/done handshake toward the drawing engine.
REQ-018 States: IDLE, ERASE_START, ERASE_WAIT, UPDATE, CHECK, DRAW_START, DRAW_WAIT, DELAY, DELAY_CLR, OVER, FAULT.
REQ-019 IDLE: go=1 -> ERASE_START; else stay.
REQ-020 ERASE_START: plot_start=1, erase=1 for exactly one cycle -> ERASE_WAIT.
REQ-021 ERASE_WAIT: erase held 1; plot_done=1 -> UPDATE.
REQ-022 UPDATE: update_pos=1 for one cycle -> CHECK.
REQ-023 CHECK: collision=1 -> OVER; else -> DRAW_START.
REQ-024 DRAW_START: plot_start=1, erase=0 for one cycle -> DRAW_WAIT; DRAW_WAIT: plot_done=1 -> DELAY.
REQ-025 DELAY: delay_en=1 held; delay_done=1 -> DELAY_CLR with delay_en=0 on the next cycle.
REQ-026 DELAY_CLR: delay_clr_n=0 for one cycle, frame_count increments by 1 (wraps 2^FRAME_W-1 -> 0); go=1 -> ERASE_START, go=0 -> IDLE.
REQ-027 plot_done SHALL be ignored in every state except ERASE_WAIT and DRAW_WAIT, including the same cycle as plot_start.
REQ-028 delay_done SHALL be ignored outside DELAY.
REQ-029 go falling mid-frame SHALL NOT abort the frame; decision made only in DELAY_CLR.
REQ-030 OVER: game_over=1; stays until go=0, then IDLE with game_over cleared.
REQ-031 Watchdog: counter clears on entry to ERASE_WAIT, DRAW_WAIT, DELAY; increments each cycle in those states; reaching TIMEOUT_CYCLES before the awaited done -> FAULT.
REQ-032 FAULT: fault=1, delay_en=0, plot_start=0; exit only via resetn.
REQ-033 Done and timeout in the same cycle: done SHALL win.

Reset
REQ-034 resetn=0 SHALL force IDLE, watchdog=0, frame_count=0, plot_start=0, erase=0, update_pos=0, delay_en=0, delay_clr_n=1, game_over=0, fault=0, regardless of current state.
REQ-035 Deassertion SHALL take effect at the next posedge; no handshake state survives reset.

Structure
REQ-036 Package frame_seq_pkg SHALL hold the state enumeration and the default TIMEOUT_CYCLES constant.
REQ-037 One sub-module, wait_watchdog (clear, count-enable, limit -> expired), SHALL implement the timeout counter.

Verification (bench TIMEOUT_CYCLES=16)
REQ-038 go=1, plot_done 3 cycles after each plot_start, delay_done 5 cycles after delay_en, collision=0 -> plot_start twice per frame (erase=1 then 0), one update_pos, one delay_clr_n low pulse, frame_count=1 after frame.
REQ-039 collision=1 in CHECK -> game_over=1, no second plot_start; go=0 -> IDLE, game_over=0.
REQ-040 plot_done never returned -> fault=1 exactly 16 cycles after ERASE_WAIT entry; stays in FAULT until resetn.
REQ-041 plot_done asserted in ERASE_START cycle, then low -> remains in ERASE_WAIT; go=0 during DRAW_WAIT -> frame completes, frame_count+1, IDLE.
REQ-042 resetn pulsed low during DELAY -> delay_en=0, frame_count=0 immediately; preload frame_count=16'hFFFF via 65535 frames or force -> next frame yields 0.
